micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer_if.sv | 26 ++
 rtl/micro_sequencer.sv | 110 +++++++++++
 tb/tb_micro_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: control-word / decoder inputs and control-store outputs.
// master drives ib, sb, db, nssel, ccz, hold; slave drives nextst, upc, sp, stack_err.
interface micro_sequencer_if #(
  parameter int AW = 5
);
  logic [AW-1:0] ib;
  logic [AW-1:0] sb;
  logic [AW-1:0] db;
  logic [2:0]    nssel;
  logic          ccz;
  logic          hold;
  logic [AW-1:0] nextst;
  logic [AW-1:0] upc;
  logic [2:0]    sp;
  logic          stack_err;

  modport master (
    output ib, sb, db, nssel, ccz, hold,
    input  nextst, upc, sp, stack_err
  );

  modport slave (
    input  ib, sb, db, nssel, ccz, hold,
    output nextst, upc, sp, stack_err
  );
endinterface

// File: rtl/micro_sequencer.sv
// micro_sequencer: micro-address sequencer with a small return-address stack.
// Ports: clock, reset_n (async, active low), bus (slave side of micro_sequencer_if).
module micro_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  micro_sequencer_if.slave  bus
);

  localparam logic [2:0] SP_FULL = 3'(DEPTH);

  typedef enum logic [2:0] {
    NS_INC  = 3'b000,
    NS_JMP  = 3'b001,
    NS_IB   = 3'b010,
    NS_SB   = 3'b011,
    NS_CJMP = 3'b100,
    NS_CALL = 3'b101,
    NS_RET  = 3'b110,
    NS_STAY = 3'b111
  } ns_e;

  ns_e           ns;
  logic [AW-1:0] upc_q, upc_d;
  logic [2:0]    sp_q, sp_d;
  logic          err_q, err_d;
  logic [AW-1:0] stk_q [DEPTH];
  logic [AW-1:0] inc;
  logic [AW-1:0] top;
  logic [AW-1:0] nxt;
  logic          push;

  assign ns  = ns_e'(bus.nssel);
  assign inc = upc_q + AW'(1);

  // Entry sp-1 is the top of stack; empty stack reads 0.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == 3'(i + 1)) top = stk_q[i];
    end
  end

  always_comb begin
    nxt   = inc;
    upc_d = upc_q;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    if (!reset_n) begin
      nxt = '0;
    end else if (bus.hold) begin
      nxt = upc_q;
    end else begin
      unique case (ns)
        NS_INC:  nxt = inc;
        NS_JMP:  nxt = bus.db;
        NS_IB:   nxt = bus.ib;
        NS_SB:   nxt = bus.sb;
        NS_CJMP: nxt = bus.ccz ? bus.db : inc;
        NS_CALL: begin
          nxt = bus.db;
          // Overflow still jumps; the return address is lost.
          if (sp_q == SP_FULL) begin
            err_d = 1'b1;
          end else begin
            push = 1'b1;
            sp_d = sp_q + 3'd1;
          end
        end
        NS_RET: begin
          // Underflow restarts at micro-address 0.
          if (sp_q == 3'd0) begin
            nxt   = '0;
            err_d = 1'b1;
          end else begin
            nxt  = top;
            sp_d = sp_q - 3'd1;
          end
        end
        NS_STAY: nxt = upc_q;
      endcase
      upc_d = nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      upc_q <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      upc_q <= upc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (push && sp_q == 3'(i)) stk_q[i] <= inc;
      end
    end
  end

  assign bus.nextst    = nxt;
  assign bus.upc       = upc_q;
  assign bus.sp        = sp_q;
  assign bus.stack_err = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed vector table plus hand-written
// multi-cycle sequences for wrap, stack overflow/underflow, hold and reset.
module tb_micro_sequencer;

  localparam int AW = 5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  micro_sequencer_if #(.AW(AW)) bus();

  micro_sequencer #(.DEPTH(4), .AW(AW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [2:0]    ns;
    logic [AW-1:0] db;
    logic [AW-1:0] ib;
    logic [AW-1:0] sb;
    logic          ccz;
    logic          hold;
    logic [AW-1:0] en;
    logic [AW-1:0] eu;
    logic [2:0]    esp;
    logic          ee;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] ns, input logic [AW-1:0] db,
                       input logic [AW-1:0] ib, input logic [AW-1:0] sb,
                       input logic ccz, input logic hold);
    bus.nssel = ns;
    bus.db    = db;
    bus.ib    = ib;
    bus.sb    = sb;
    bus.ccz   = ccz;
    bus.hold  = hold;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string tag, input int en, input int eu,
                      input int esp, input int ee);
    #1;
    chk({tag, ".nextst"}, int'(bus.nextst), en);
    @(posedge clock);
    #1;
    chk({tag, ".upc"}, int'(bus.upc), eu);
    chk({tag, ".sp"}, int'(bus.sp), esp);
    chk({tag, ".err"}, int'(bus.stack_err), ee);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    drive(3'b000, '0, '0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rst.nextst", int'(bus.nextst), 0);
    chk("rst.upc", int'(bus.upc), 0);
    chk("rst.sp", int'(bus.sp), 0);
    chk("rst.err", int'(bus.stack_err), 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    vt[0]  = '{3'b000, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 5'd1,  5'd1,  3'd0, 1'b0};
    vt[1]  = '{3'b010, 5'd0,  5'd12, 5'd0, 1'b0, 1'b0, 5'd12, 5'd12, 3'd0, 1'b0};
    vt[2]  = '{3'b011, 5'd0,  5'd0,  5'd3, 1'b0, 1'b0, 5'd3,  5'd3,  3'd0, 1'b0};
    vt[3]  = '{3'b001, 5'd5,  5'd0,  5'd0, 1'b0, 1'b0, 5'd5,  5'd5,  3'd0, 1'b0};
    vt[4]  = '{3'b101, 5'd20, 5'd0,  5'd0, 1'b0, 1'b0, 5'd20, 5'd20, 3'd1, 1'b0};
    vt[5]  = '{3'b111, 5'd7,  5'd0,  5'd0, 1'b0, 1'b0, 5'd20, 5'd20, 3'd1, 1'b0};
    vt[6]  = '{3'b100, 5'd9,  5'd0,  5'd0, 1'b1, 1'b0, 5'd9,  5'd9,  3'd1, 1'b0};
    vt[7]  = '{3'b100, 5'd2,  5'd0,  5'd0, 1'b0, 1'b0, 5'd10, 5'd10, 3'd1, 1'b0};
    vt[8]  = '{3'b110, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 5'd6,  5'd6,  3'd0, 1'b0};
    vt[9]  = '{3'b001, 5'd17, 5'd0,  5'd0, 1'b0, 1'b1, 5'd6,  5'd6,  3'd0, 1'b0};
    vt[10] = '{3'b000, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 5'd7,  5'd7,  3'd0, 1'b0};

    drive(3'b000, '0, '0, '0, 1'b0, 1'b0);

    // Vector table from a fresh reset.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].ns, vt[i].db, vt[i].ib, vt[i].sb, vt[i].ccz, vt[i].hold);
      step($sformatf("vec%0d", i), int'(vt[i].en), int'(vt[i].eu),
           int'(vt[i].esp), int'(vt[i].ee));
    end

    // Sequential count over 33 edges: 1..31, 0, 1.
    do_reset();
    drive(3'b000, '0, '0, '0, 1'b0, 1'b0);
    for (int k = 1; k <= 33; k++) begin
      step($sformatf("cnt%0d", k), k % 32, k % 32, 0, 0);
    end

    // Five calls overflow a 4-deep stack; returns come back in reverse.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(3'b101, 5'(10 + k), '0, '0, 1'b0, 1'b0);
      step($sformatf("call%0d", k), 10 + k, 10 + k,
           (k < 4) ? k + 1 : 4, (k < 4) ? 0 : 1);
    end
    drive(3'b110, '0, '0, '0, 1'b0, 1'b0);
    step("ret0", 13, 13, 3, 1);
    step("ret1", 12, 12, 2, 1);
    step("ret2", 11, 11, 1, 1);
    step("ret3", 1, 1, 0, 1);
    step("ret4", 0, 0, 0, 1);

    // Underflow from empty, then the flag stays until reset.
    do_reset();
    drive(3'b110, '0, '0, '0, 1'b0, 1'b0);
    step("uf", 0, 0, 0, 1);
    drive(3'b000, '0, '0, '0, 1'b0, 1'b0);
    step("uf.stick0", 1, 1, 0, 1);
    step("uf.stick1", 2, 2, 0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("uf.clr.err", int'(bus.stack_err), 0);
    chk("uf.clr.upc", int'(bus.upc), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Hold for three cycles over a call, then the call completes once.
    do_reset();
    drive(3'b000, '0, '0, '0, 1'b0, 1'b0);
    step("h.pre", 1, 1, 0, 0);
    drive(3'b101, 5'd20, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step($sformatf("hold%0d", k), 1, 1, 0, 0);
    end
    drive(3'b101, 5'd20, '0, '0, 1'b0, 1'b0);
    step("h.call", 20, 20, 1, 0);
    drive(3'b111, '0, '0, '0, 1'b0, 1'b0);
    step("h.stay", 20, 20, 1, 0);
    drive(3'b110, '0, '0, '0, 1'b0, 1'b0);
    step("h.ret", 2, 2, 0, 0);

    // Reset during a pending call discards the push.
    do_reset();
    drive(3'b000, '0, '0, '0, 1'b0, 1'b0);
    step("mr.pre", 1, 1, 0, 0);
    drive(3'b101, 5'd25, '0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mr.nextst", int'(bus.nextst), 0);
    @(posedge clock);
    #1;
    chk("mr.sp", int'(bus.sp), 0);
    chk("mr.upc", int'(bus.upc), 0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(3'b110, '0, '0, '0, 1'b0, 1'b0);
    step("mr.ret", 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
